// File: rtl/write_buffer.sv
// Posted-write buffer between cache and RAM: queues writes, drains them in the
// background, lets read misses bypass the queue and forwards reads that hit it.
module write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_address,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_ready,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_empty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRdMem, StWrMem, StResp} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PtrW-1:0]   head_q, tail_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              wr_full_q, wr_empty_q;
    logic              mem_req_q, mem_we_q, rd_ready_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_wdata_q, rd_data_q;

    logic              push, pop, drain_go;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign push     = wr_req & ~wr_full_q;
    assign pop      = (state_q == StWrMem) & mem_ready;
    assign count_d  = count_q + CntW'(push) - CntW'(pop);
    // A full buffer must drain before anything else; otherwise reads go first.
    assign drain_go = wr_full_q | (~rd_req & (count_q != '0));

    // Walk from head to tail so the newest matching entry wins; the incoming
    // write overrides everything stored.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CntW'(k) < count_q) && (addr_mem[head_q + PtrW'(k)] == rd_address)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[head_q + PtrW'(k)];
            end
        end
        if (push && (wr_address == rd_address)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= wr_address;
            data_mem[tail_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            wr_full_q     <= 1'b0;
            wr_empty_q    <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            rd_ready_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            count_q    <= count_d;
            wr_full_q  <= (count_d == FullCnt);
            wr_empty_q <= (count_d == '0);
            if (push) tail_q <= tail_q + PtrW'(1);
            if (pop)  head_q <= head_q + PtrW'(1);

            case (state_q)
                StIdle: begin
                    if (drain_go) begin
                        state_q       <= StWrMem;
                        mem_req_q     <= 1'b1;
                        mem_we_q      <= 1'b1;
                        mem_address_q <= addr_mem[head_q];
                        mem_wdata_q   <= data_mem[head_q];
                    end else if (rd_req && fwd_hit) begin
                        state_q    <= StResp;
                        rd_data_q  <= fwd_data;
                        rd_ready_q <= 1'b1;
                    end else if (rd_req) begin
                        state_q       <= StRdMem;
                        mem_req_q     <= 1'b1;
                        mem_we_q      <= 1'b0;
                        mem_address_q <= rd_address;
                    end
                end
                StRdMem: begin
                    if (mem_ready) begin
                        state_q    <= StResp;
                        mem_req_q  <= 1'b0;
                        rd_data_q  <= mem_rdata;
                        rd_ready_q <= 1'b1;
                    end
                end
                StWrMem: begin
                    if (mem_ready) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                StResp: begin
                    state_q    <= StIdle;
                    rd_ready_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_full     = wr_full_q;
    assign wr_empty    = wr_empty_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign rd_ready    = rd_ready_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer with a latency-programmable RAM model that
// logs every completed RAM transaction in order.
module tb_write_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [31:0] rd_address = '0;
    logic [63:0] rd_data;
    logic        rd_ready;
    logic        wr_req = 1'b0;
    logic [31:0] wr_address = '0;
    logic [63:0] wr_data = '0;
    logic        wr_full, wr_empty;
    logic        mem_req, mem_we;
    logic [31:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    int total = 0;
    int bad = 0;
    int ram_lat = 1;

    logic [63:0] ram [logic [31:0]];
    logic        log_we [$];
    logic [31:0] log_addr [$];
    logic [63:0] log_data [$];

    write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_address(rd_address), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_req(wr_req), .wr_address(wr_address), .wr_data(wr_data),
        .wr_full(wr_full), .wr_empty(wr_empty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ram_default(input logic [31:0] a);
        return {32'hD0D0_0000, a};
    endfunction

    function automatic logic [96:0] get_log(input int idx);
        if (idx < 0 || idx >= log_addr.size()) return '1;
        return {log_we[idx], log_addr[idx], log_data[idx]};
    endfunction

    // RAM: responds ram_lat cycles after it first sees mem_req, forgets on drop.
    initial begin : ram_model
        int wait_cnt;
        wait_cnt  = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req && rst) begin
                if (wait_cnt >= ram_lat) begin
                    mem_ready = 1'b1;
                    wait_cnt  = 0;
                    if (mem_we) begin
                        ram[mem_address] = mem_wdata;
                        log_data.push_back(mem_wdata);
                    end else begin
                        mem_rdata = ram.exists(mem_address) ? ram[mem_address]
                                                            : ram_default(mem_address);
                        log_data.push_back(mem_rdata);
                    end
                    log_we.push_back(mem_we);
                    log_addr.push_back(mem_address);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [31:0] a, input logic [63:0] d);
        wr_req = 1'b1;
        wr_address = a;
        wr_data = d;
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(wr_empty && !mem_req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(wr_empty && !mem_req)) begin
            bad++;
            $display("FAIL %s idle: wr_empty=%0b mem_req=%0b, required 1 and 0", name, wr_empty,
                     mem_req);
        end
    endtask

    task automatic wait_rd(input string name, input bit drop_wr, output logic [63:0] data,
                           output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (drop_wr) wr_req = 1'b0;
        end while (!rd_ready && lat < 300);
        total++;
        if (!rd_ready) begin
            bad++;
            $display("FAIL %s rd_ready: got 0 after %0d cycles, required 1", name, lat);
        end
        data = rd_data;
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        int lat, base;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({mem_req, mem_we, rd_ready, wr_full, wr_empty} !== 5'b00001) begin
            bad++;
            $display("FAIL reset flags: got %b required 00001",
                     {mem_req, mem_we, rd_ready, wr_full, wr_empty});
        end
        total++;
        if ({mem_address, mem_wdata, rd_data} !== '0) begin
            bad++;
            $display("FAIL reset data: got addr=%h wdata=%h rdata=%h required zero", mem_address,
                     mem_wdata, rd_data);
        end
        rst = 1'b1;
        @(negedge clk);
        ram_lat = 5;
        push(32'h10, 64'h1);
        push(32'h20, 64'h2);
        push(32'h30, 64'h3);
        total++;
        if ({mem_req, mem_we, mem_address} !== {2'b11, 32'h10}) begin
            bad++;
            $display("FAIL reset drain start: got req=%b we=%b addr=%h required 1 1 10", mem_req,
                     mem_we, mem_address);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({mem_req, wr_empty} !== 2'b01) begin
            bad++;
            $display("FAIL reset async: got mem_req=%b wr_empty=%b required 0 1", mem_req,
                     wr_empty);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        base = log_addr.size();
        rd_req = 1'b1;
        rd_address = 32'h20;
        wait_rd("reset read", 1'b0, d, lat);
        total++;
        if (d !== ram_default(32'h20)) begin
            bad++;
            $display("FAIL reset read data: got %h required %h", d, ram_default(32'h20));
        end
        wait_idle("reset");
        total++;
        if (log_addr.size() !== base + 1 || get_log(base) !== {1'b0, 32'h20, ram_default(32'h20)})
        begin
            bad++;
            $display("FAIL reset ram log: got %0d entries, first %h, required 1 read of 20",
                     log_addr.size() - base, get_log(base));
        end
    endtask

    task automatic test_fwd_read();
        logic [63:0] d;
        int lat, base;
        ram_lat = 1;
        wait_idle("fwd pre");
        base = log_addr.size();
        push(32'h100, 64'hAAAA);
        rd_req = 1'b1;
        rd_address = 32'h100;
        wait_rd("fwd", 1'b0, d, lat);
        total++;
        if (d !== 64'hAAAA || lat !== 1) begin
            bad++;
            $display("FAIL fwd read: got data=%h lat=%0d required AAAA lat=1", d, lat);
        end
        wait_idle("fwd");
        total++;
        if (log_addr.size() !== base + 1 || get_log(base) !== {1'b1, 32'h100, 64'hAAAA}) begin
            bad++;
            $display("FAIL fwd ram log: got %0d entries, first %h, required single write",
                     log_addr.size() - base, get_log(base));
        end
    endtask

    task automatic test_read_priority();
        logic [63:0] d;
        logic [96:0] exp_log [3];
        int lat, base;
        ram_lat = 1;
        wait_idle("prio pre");
        base = log_addr.size();
        push(32'h300, 64'h11);
        wr_req = 1'b1;
        wr_address = 32'h304;
        wr_data = 64'h22;
        rd_req = 1'b1;
        rd_address = 32'h200;
        wait_rd("prio", 1'b1, d, lat);
        total++;
        if (d !== ram_default(32'h200)) begin
            bad++;
            $display("FAIL prio read data: got %h required %h", d, ram_default(32'h200));
        end
        wait_idle("prio");
        exp_log[0] = {1'b0, 32'h200, ram_default(32'h200)};
        exp_log[1] = {1'b1, 32'h300, 64'h11};
        exp_log[2] = {1'b1, 32'h304, 64'h22};
        for (int i = 0; i < 3; i++) begin
            total++;
            if (get_log(base + i) !== exp_log[i]) begin
                bad++;
                $display("FAIL prio ram order[%0d]: got %h required %h", i, get_log(base + i),
                         exp_log[i]);
            end
        end
    endtask

    task automatic test_newest_wins();
        logic [63:0] d;
        int lat, base;
        ram_lat = 3;
        wait_idle("newest pre");
        base = log_addr.size();
        push(32'h40, 64'd1);
        push(32'h40, 64'd2);
        push(32'h40, 64'd3);
        rd_req = 1'b1;
        rd_address = 32'h40;
        wait_rd("newest", 1'b0, d, lat);
        total++;
        if (d !== 64'd3) begin
            bad++;
            $display("FAIL newest read: got %h required 3", d);
        end
        wait_idle("newest");
        total++;
        if (log_addr.size() !== base + 3) begin
            bad++;
            $display("FAIL newest ram count: got %0d required 3", log_addr.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (get_log(base + i) !== {1'b1, 32'h40, 64'(i + 1)}) begin
                bad++;
                $display("FAIL newest ram order[%0d]: got %h required write 40 data %0d", i,
                         get_log(base + i), i + 1);
            end
        end
    endtask

    task automatic test_full();
        logic [63:0] d;
        logic [96:0] exp_log [6];
        int lat, base, n;
        bit got;
        ram_lat = 6;
        wait_idle("full pre");
        base = log_addr.size();
        rd_req = 1'b1;
        rd_address = 32'h600;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 4), 64'hF0 + 64'(i));
        total++;
        if (wr_full !== 1'b1 || wr_empty !== 1'b0) begin
            bad++;
            $display("FAIL full flags: got full=%b empty=%b required 1 0", wr_full, wr_empty);
        end
        wr_req = 1'b1;
        wr_address = 32'h2000;
        wr_data = 64'hBAD;
        wait_rd("full first read", 1'b0, d, lat);
        total++;
        if (d !== ram_default(32'h600)) begin
            bad++;
            $display("FAIL full first read: got %h required %h", d, ram_default(32'h600));
        end
        @(negedge clk);
        rd_req = 1'b1;
        rd_address = 32'h700;
        got = 1'b0;
        n = 0;
        d = '0;
        // Hold the extra write across the pop edge, release once full clears.
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (wr_req && !wr_full) wr_req = 1'b0;
            if (rd_ready) begin
                got = 1'b1;
                d = rd_data;
                rd_req = 1'b0;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        total++;
        if (!got || d !== ram_default(32'h700)) begin
            bad++;
            $display("FAIL full pending read: got ready=%b data=%h required 1 %h", got, d,
                     ram_default(32'h700));
        end
        wait_idle("full");
        exp_log[0] = {1'b0, 32'h600, ram_default(32'h600)};
        exp_log[1] = {1'b1, 32'h1000, 64'hF0};
        exp_log[2] = {1'b0, 32'h700, ram_default(32'h700)};
        exp_log[3] = {1'b1, 32'h1004, 64'hF1};
        exp_log[4] = {1'b1, 32'h1008, 64'hF2};
        exp_log[5] = {1'b1, 32'h100C, 64'hF3};
        total++;
        if (log_addr.size() !== base + 6) begin
            bad++;
            $display("FAIL full ram count: got %0d required 6 (dropped push must not appear)",
                     log_addr.size() - base);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (get_log(base + i) !== exp_log[i]) begin
                bad++;
                $display("FAIL full ram order[%0d]: got %h required %h", i, get_log(base + i),
                         exp_log[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int base, i, n;
        ram_lat = 0;
        wait_idle("wrap pre");
        base = log_addr.size();
        i = 0;
        n = 0;
        while (i < 10 && n < 500) begin
            if (!wr_full) begin
                wr_req = 1'b1;
                wr_address = 32'h3000 + 32'(i * 8);
                wr_data = 64'h5000 + 64'(i);
                i++;
            end else begin
                wr_req = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        wr_req = 1'b0;
        wait_idle("wrap");
        total++;
        if (log_addr.size() !== base + 10) begin
            bad++;
            $display("FAIL wrap ram count: got %0d required 10", log_addr.size() - base);
        end
        for (int k = 0; k < 10; k++) begin
            total++;
            if (get_log(base + k) !== {1'b1, 32'h3000 + 32'(k * 8), 64'h5000 + 64'(k)}) begin
                bad++;
                $display("FAIL wrap ram order[%0d]: got %h required write %h", k,
                         get_log(base + k), 32'h3000 + 32'(k * 8));
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [63:0] d;
        int lat, base;
        ram_lat = 1;
        wait_idle("same pre");
        base = log_addr.size();
        push(32'h80, 64'h33);
        wr_req = 1'b1;
        wr_address = 32'h80;
        wr_data = 64'h55;
        rd_req = 1'b1;
        rd_address = 32'h80;
        wait_rd("same", 1'b1, d, lat);
        total++;
        if (d !== 64'h55 || lat !== 1) begin
            bad++;
            $display("FAIL same-cycle read: got data=%h lat=%0d required 55 lat=1", d, lat);
        end
        wait_idle("same");
        total++;
        if (log_addr.size() !== base + 2 || get_log(base) !== {1'b1, 32'h80, 64'h33} ||
            get_log(base + 1) !== {1'b1, 32'h80, 64'h55}) begin
            bad++;
            $display("FAIL same-cycle ram log: got %0d entries %h %h required writes 33 then 55",
                     log_addr.size() - base, get_log(base), get_log(base + 1));
        end
        rd_req = 1'b1;
        rd_address = 32'h80;
        wait_rd("same reread", 1'b0, d, lat);
        total++;
        if (d !== 64'h55 || get_log(base + 2) !== {1'b0, 32'h80, 64'h55}) begin
            bad++;
            $display("FAIL same-cycle reread: got data=%h log=%h required RAM read of 55", d,
                     get_log(base + 2));
        end
    endtask

    initial begin
        test_reset();
        test_fwd_read();
        test_read_priority();
        test_newest_wins();
        test_full();
        test_wrap();
        test_same_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
